// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - parametrised up/down modulo counter with wrap/saturate and event flags
module mod_updown_counter #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             at_max, at_zero;
  logic             step_up, step_dn;

  assign at_max  = (count_q == MAX_VAL);
  assign at_zero = (count_q == ZERO);

  // A count step only happens when neither clear nor load claims the edge.
  assign step_up = en & ~clr & ~load & up_dn;
  assign step_dn = en & ~clr & ~load & ~up_dn;

  // Terminal count flags the edge that is about to wrap or be blocked.
  assign tc = (step_up & at_max) | (step_dn & at_zero);

  // Next-state: clear beats load beats counting; out-of-range loads clamp to the top.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (clr) begin
      count_d = ZERO;
    end else if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (step_up) begin
      if (!at_max) begin
        count_d = count_q + ONE;
      end else if (SATURATE) begin
        sat_d = 1'b1;
      end else begin
        count_d = ZERO;
        wrap_d  = 1'b1;
      end
    end else if (step_dn) begin
      if (!at_zero) begin
        count_d = count_q - ONE;
      end else if (SATURATE) begin
        sat_d = 1'b1;
      end else begin
        count_d = MAX_VAL;
        wrap_d  = 1'b1;
      end
    end
  end

  // State register; event flags land in the same cycle as the count they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= ZERO;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - scoreboard bench for mod_updown_counter in three configurations
module tb_mod_updown_counter;

  typedef struct {
    int    dut;
    int    cnt;
    bit    wrp;
    bit    sta;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       clr_s  [3];
  logic       load_s [3];
  logic [7:0] lv_s   [3];
  logic       en_s   [3];
  logic       up_s   [3];
  logic [3:0] cnt0, cnt1;
  logic [7:0] cnt2;
  logic       tc_s   [3];
  logic       wrap_s [3];
  logic       sat_s  [3];

  int   n_chk;
  int   n_err;
  int   mcnt [3];
  int   mmax [3];
  bit   msat [3];
  exp_t sb [$];

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr_s[0]), .load(load_s[0]), .load_val(lv_s[0][3:0]),
    .en(en_s[0]), .up_dn(up_s[0]), .count(cnt0), .tc(tc_s[0]), .wrap(wrap_s[0]), .sat(sat_s[0])
  );

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr_s[1]), .load(load_s[1]), .load_val(lv_s[1][3:0]),
    .en(en_s[1]), .up_dn(up_s[1]), .count(cnt1), .tc(tc_s[1]), .wrap(wrap_s[1]), .sat(sat_s[1])
  );

  mod_updown_counter #(.WIDTH(8)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr_s[2]), .load(load_s[2]), .load_val(lv_s[2]),
    .en(en_s[2]), .up_dn(up_s[2]), .count(cnt2), .tc(tc_s[2]), .wrap(wrap_s[2]), .sat(sat_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_cnt(input int d);
    case (d)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // One clock of stimulus on DUT d: check tc now, queue the expected post-edge state, compare after the edge.
  task automatic step(input string tag, input int d, input bit c, input bit l,
                      input int lv, input bit e, input bit u);
    exp_t x;
    exp_t y;
    bit   etc;
    clr_s[d] = c; load_s[d] = l; lv_s[d] = lv[7:0]; en_s[d] = e; up_s[d] = u;
    #1;
    etc = e && !c && !l && ((u && mcnt[d] == mmax[d]) || (!u && mcnt[d] == 0));
    check({tag, ".tc"}, int'(tc_s[d]), int'(etc));
    x.dut = d; x.cnt = mcnt[d]; x.wrp = 1'b0; x.sta = 1'b0;
    if (c) begin
      x.cnt = 0;
    end else if (l) begin
      x.cnt = (lv > mmax[d]) ? mmax[d] : lv;
    end else if (e && u) begin
      if (mcnt[d] < mmax[d]) x.cnt = mcnt[d] + 1;
      else if (msat[d])      x.sta = 1'b1;
      else begin x.cnt = 0; x.wrp = 1'b1; end
    end else if (e) begin
      if (mcnt[d] > 0)       x.cnt = mcnt[d] - 1;
      else if (msat[d])      x.sta = 1'b1;
      else begin x.cnt = mmax[d]; x.wrp = 1'b1; end
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    clr_s[d] = 1'b0; load_s[d] = 1'b0; en_s[d] = 1'b0;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 0, 1);
    end else begin
      y = sb.pop_front();
      check({tag, ".count"}, get_cnt(y.dut), y.cnt);
      check({tag, ".wrap"}, int'(wrap_s[y.dut]), int'(y.wrp));
      check({tag, ".sat"}, int'(sat_s[y.dut]), int'(y.sta));
      mcnt[y.dut] = y.cnt;
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    mmax[0] = 9;   msat[0] = 1'b0;
    mmax[1] = 9;   msat[1] = 1'b1;
    mmax[2] = 255; msat[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clr_s[i] = 1'b0; load_s[i] = 1'b0; lv_s[i] = 8'd0; en_s[i] = 1'b0; up_s[i] = 1'b1;
      mcnt[i] = 0;
    end
    rst = 1'b0;

    // Reset state, and tc follows its equation while held in reset.
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst.count", get_cnt(i), 0);
      check("rst.wrap", int'(wrap_s[i]), 0);
      check("rst.sat", int'(sat_s[i]), 0);
      check("rst.tc_idle", int'(tc_s[i]), 0);
    end
    en_s[0] = 1'b1; up_s[0] = 1'b0;
    #1;
    check("rst.tc_down", int'(tc_s[0]), 1);
    en_s[0] = 1'b0; up_s[0] = 1'b1;
    #10;
    rst = 1'b1;

    // Decade count up through a wrap.
    for (int i = 0; i < 12; i++) step("up_wrap", 0, 0, 0, 0, 1, 1);

    // Load then count down through a wrap.
    step("ld2", 0, 0, 1, 2, 0, 1);
    for (int i = 0; i < 4; i++) step("dn_wrap", 0, 0, 0, 0, 1, 0);

    // Saturating variant at both ends.
    step("s_ld7", 1, 0, 1, 7, 0, 1);
    for (int i = 0; i < 5; i++) step("s_up", 1, 0, 0, 0, 1, 1);
    step("s_ld1", 1, 0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) step("s_dn", 1, 0, 0, 0, 1, 0);

    // Priority clr > load > en, and load clamping.
    step("p_ld5", 0, 0, 1, 5, 0, 1);
    step("p_clr", 0, 1, 1, 7, 1, 1);
    step("p_clamp", 0, 0, 1, 15, 1, 1);

    // Asynchronous reset between edges.
    step("a_ld6", 0, 0, 1, 6, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst.count", get_cnt(0), 0);
    check("arst.wrap", int'(wrap_s[0]), 0);
    check("arst.sat", int'(sat_s[0]), 0);
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    #1;
    rst = 1'b1;
    step("a_first", 0, 0, 0, 0, 1, 1);

    // 8-bit full-range counter.
    step("w_ld254", 2, 0, 1, 254, 0, 1);
    for (int i = 0; i < 3; i++) step("w_up", 2, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step("w_hold", 2, 0, 0, 0, 0, 1);

    // Mixed random traffic on every configuration.
    for (int i = 0; i < 150; i++) begin
      int d;
      int r;
      d = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 15));
      step("rnd", d, r == 0, r == 1, int'($urandom_range(0, 255)) & ((d == 2) ? 255 : 15),
           r != 2, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
